// File: rtl/spi_ram_master_if.sv
// Command/response port and serial pins of the SPI RAM master.
`timescale 1ns/1ps
interface spi_ram_master_if;
  // Handshake: the requester raises cmd_valid with stable cmd_op/cmd_data and holds them
  // until a rising edge on which cmd_ready is also high; that edge transfers the command.
  // cmd_ready never depends on cmd_valid. rsp_valid is a one-cycle pulse with no
  // back-pressure; rsp_data holds the last read byte until the next pulse.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       ss_n;
  logic       mosi;
  logic       miso;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, miso,
    output cmd_ready, rsp_valid, rsp_data, busy, ss_n, mosi
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, miso,
    input  cmd_ready, rsp_valid, rsp_data, busy, ss_n, mosi
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master that serialises one RAM command per handshake into a slave frame and
// returns the read byte of read-data commands on a one-cycle strobe.
`timescale 1ns/1ps
module spi_ram_master #(
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  spi_ram_master_if.master bus,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RECV  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;

  // Counter loads are length-1: a phase ends on the edge where the counter reads zero.
  localparam logic [3:0] SHIFT_LOAD    = 4'd9;
  localparam logic [3:0] RECV_LOAD     = 4'd7;
  localparam logic [3:0] WAIT_LOAD     = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
  localparam logic [3:0] GAP_LOAD      = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [3:0] RESP_GAP_LOAD = (GAP_CYCLES > 1) ? 4'(GAP_CYCLES - 2) : 4'd0;

  localparam logic [1:0] OP_RD_DATA = 2'b11;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] shreg_q, shreg_d;
  logic [7:0] rx_q, rx_d;
  logic       is_rd_q, is_rd_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       accept;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign bus.ss_n      = ss_n_q;
  assign bus.mosi      = mosi_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign dbg_state     = state_q;

  // The *_d values of ss_n/mosi/rsp_* are what the pins show after the coming edge,
  // so each pin lags the state that produced it by one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rx_d        = rx_q;
    is_rd_d     = is_rd_q;
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = {bus.cmd_op, bus.cmd_data};
          is_rd_d = (bus.cmd_op == OP_RD_DATA);
          state_d = ST_START;
        end
      end

      ST_START: begin
        // shreg_q[9] is cmd_op[1], the slave's read/write select bit.
        ss_n_d  = 1'b0;
        mosi_d  = shreg_q[9];
        cnt_d   = SHIFT_LOAD;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        ss_n_d  = 1'b0;
        mosi_d  = shreg_q[9];
        shreg_d = {shreg_q[8:0], 1'b0};
        if (cnt_q == 4'd0) begin
          if (is_rd_q) begin
            if (RD_WAIT == 0) begin
              cnt_d   = RECV_LOAD;
              state_d = ST_RECV;
            end else begin
              cnt_d   = WAIT_LOAD;
              state_d = ST_WAIT;
            end
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_WAIT: begin
        ss_n_d = 1'b0;
        if (cnt_q == 4'd0) begin
          cnt_d   = RECV_LOAD;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RECV: begin
        ss_n_d = 1'b0;
        rx_d   = {rx_q[6:0], bus.miso};
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        // This cycle already counts as the first gap cycle after a read.
        rsp_valid_d = 1'b1;
        rsp_data_d  = rx_q;
        if (GAP_CYCLES > 1) begin
          cnt_d   = RESP_GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      shreg_q     <= 10'd0;
      rx_q        <= 8'd0;
      is_rd_q     <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_q        <= rx_d;
      is_rd_q     <= is_rd_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two builds (default and RD_WAIT=0/GAP_CYCLES=3) each talking
// to a behavioural SPI RAM slave; a command-level RAM model supplies expected data.
`timescale 1ns/1ps
module tb_spi_ram_master;

  localparam int RW0 = 2;
  localparam int G0  = 1;
  localparam int RW1 = 0;
  localparam int G1  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUTs ----------------
  spi_ram_master_if bus0();
  spi_ram_master_if bus1();
  logic [2:0] dbg0, dbg1;

  spi_ram_master #(.RD_WAIT(RW0), .GAP_CYCLES(G0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master), .dbg_state(dbg0)
  );
  spi_ram_master #(.RD_WAIT(RW1), .GAP_CYCLES(G1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master), .dbg_state(dbg1)
  );

  logic [1:0] cmd_valid_v = 2'b00;
  logic [1:0] miso_v      = 2'b00;
  logic [1:0] cmd_op_a[2];
  logic [7:0] cmd_data_a[2];

  assign bus0.cmd_valid = cmd_valid_v[0];
  assign bus1.cmd_valid = cmd_valid_v[1];
  assign bus0.cmd_op    = cmd_op_a[0];
  assign bus1.cmd_op    = cmd_op_a[1];
  assign bus0.cmd_data  = cmd_data_a[0];
  assign bus1.cmd_data  = cmd_data_a[1];
  assign bus0.miso      = miso_v[0];
  assign bus1.miso      = miso_v[1];

  wire [1:0] ready_v     = {bus1.cmd_ready, bus0.cmd_ready};
  wire [1:0] busy_v      = {bus1.busy, bus0.busy};
  wire [1:0] ss_n_v      = {bus1.ss_n, bus0.ss_n};
  wire [1:0] mosi_v      = {bus1.mosi, bus0.mosi};
  wire [1:0] rsp_valid_v = {bus1.rsp_valid, bus0.rsp_valid};
  logic [7:0] rsp_data_a[2];
  assign rsp_data_a[0] = bus0.rsp_data;
  assign rsp_data_a[1] = bus1.rsp_data;

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_ram[2][256];
  logic [7:0]  ref_addr[2];
  logic [11:0] exp_q[$];   // {channel, select bit, op, data}
  logic [11:0] obs_q[$];

  // ---------------- behavioural SPI RAM slave ----------------
  int         s_bits[2];
  logic [10:0] s_frm[2];
  logic [7:0] s_addr[2];
  logic [7:0] s_ram[2][256];
  logic [7:0] s_tx[2];
  int         s_dly[2];
  int         s_sent[2];
  int         low_cnt[2];
  int         rsp_cnt[2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      s_bits[c] = 0; s_sent[c] = 8; s_dly[c] = 0; s_addr[c] = 8'h00;
      low_cnt[c] = 0; rsp_cnt[c] = 0; ref_addr[c] = 8'h00;
      for (int a = 0; a < 256; a++) begin
        s_ram[c][a] = 8'h00;
        ref_ram[c][a] = 8'h00;
      end
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (rsp_valid_v[c]) rsp_cnt[c]++;
        if (!ss_n_v[c]) low_cnt[c]++;
        if (rst || ss_n_v[c]) begin
          s_bits[c] = 0;
          s_sent[c] = 8;
          miso_v[c] = 1'b0;
        end else begin
          if (s_bits[c] < 11) begin
            s_frm[c] = {s_frm[c][9:0], mosi_v[c]};
            s_bits[c]++;
            if (s_bits[c] == 11) begin
              obs_q.push_back({c[0], s_frm[c]});
              case (s_frm[c][9:8])
                2'b00: s_addr[c] = s_frm[c][7:0];
                2'b01: s_ram[c][s_addr[c]] = s_frm[c][7:0];
                2'b10: s_addr[c] = s_frm[c][7:0];
                default: begin
                  s_tx[c]   = s_ram[c][s_addr[c]];
                  s_dly[c]  = (c == 0) ? RW0 : RW1;
                  s_sent[c] = 0;
                end
              endcase
            end
          end
          if (s_sent[c] < 8) begin
            if (s_dly[c] > 0) begin
              s_dly[c]--;
              miso_v[c] = 1'b0;
            end else begin
              miso_v[c] = s_tx[c][7 - s_sent[c]];
              s_sent[c]++;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_cmd(input int c, input logic [1:0] op, input logic [7:0] d);
    logic [0:0] ch;
    ch = 1'(c);
    exp_q.push_back({ch, op[1], op, d});
    if (op == 2'b00 || op == 2'b10) ref_addr[c] = d;
    else if (op == 2'b01) ref_ram[c][ref_addr[c]] = d;
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Returns the index of the accepting edge; leaves time at #1 after that edge.
  task automatic issue(input int c, input logic [1:0] op, input logic [7:0] d,
                       output int k);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid_v[c] = 1'b1;
    cmd_op_a[c]    = op;
    cmd_data_a[c]  = d;
    while (ready_v[c] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL accept_timeout ch%0d: cmd_ready=%b, required 1", c, ready_v[c]);
    end
    @(posedge clk); #1;
    k = cyc;
    cmd_valid_v[c] = 1'b0;
    model_cmd(c, op, d);
  endtask

  task automatic wait_idle(input int c);
    int n;
    n = 0;
    while (ready_v[c] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL idle_timeout ch%0d: cmd_ready=%b, required 1", c, ready_v[c]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({ss_n_v[c], mosi_v[c], rsp_valid_v[c], busy_v[c], rsp_data_a[c]} !== {4'b1000, 8'h00}) begin
        errors++;
        $display("FAIL reset_outputs ch%0d: ss_n=%b mosi=%b rsp_valid=%b busy=%b rsp_data=%h, required 1 0 0 0 00",
                 c, ss_n_v[c], mosi_v[c], rsp_valid_v[c], busy_v[c], rsp_data_a[c]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (ready_v[c] !== 1'b1 || ss_n_v[c] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready ch%0d: cmd_ready=%b ss_n=%b, required 1 1", c, ready_v[c], ss_n_v[c]);
      end
    end
  endtask

  task automatic test_write_frames;
    logic [1:0]  ops[6];
    logic [7:0]  dats[6];
    logic [10:0] exp_bits;
    int k, lc0;
    ops[0] = 2'b00; dats[0] = 8'h0A;
    ops[1] = 2'b01; dats[1] = 8'h5C;
    for (int i = 2; i < 6; i++) begin
      ops[i]  = 2'($urandom_range(0, 2));
      dats[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 6; i++) begin
      exp_bits = {ops[i][1], ops[i], dats[i]};
      lc0 = low_cnt[0];
      issue(0, ops[i], dats[i], k);
      checks++;
      if (busy_v[0] !== 1'b1 || ready_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL wr_busy_after_accept #%0d: busy=%b cmd_ready=%b, required 1 0", i, busy_v[0], ready_v[0]);
      end
      for (int m = 1; m <= 12 + G0; m++) begin
        wait_edge(k + m);
        if (m <= 11) begin
          checks++;
          if (ss_n_v[0] !== 1'b0 || mosi_v[0] !== exp_bits[11 - m]) begin
            errors++;
            $display("FAIL wr_bit #%0d m=%0d: ss_n=%b mosi=%b, required 0 %b", i, m, ss_n_v[0], mosi_v[0], exp_bits[11 - m]);
          end
        end else if (m == 12) begin
          checks++;
          if (ss_n_v[0] !== 1'b1 || mosi_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_frame_end #%0d: ss_n=%b mosi=%b, required 1 0", i, ss_n_v[0], mosi_v[0]);
          end
        end
        if (m == 10 + G0 || m == 11 + G0) begin
          checks++;
          if (ready_v[0] !== (m == 11 + G0)) begin
            errors++;
            $display("FAIL wr_ready_return #%0d m=%0d: cmd_ready=%b, required %b", i, m, ready_v[0], (m == 11 + G0));
          end
        end
      end
      checks++;
      if (low_cnt[0] - lc0 != 11) begin
        errors++;
        $display("FAIL wr_ss_low_len #%0d: %0d cycles, required 11", i, low_cnt[0] - lc0);
      end
      if (i == 1) begin
        checks++;
        if (s_ram[0][8'h0A] !== 8'h5C) begin
          errors++;
          $display("FAIL wr_slave_ram: ram[0A]=%h, required 5c", s_ram[0][8'h0A]);
        end
      end
    end
    while (exp_q.size() > 0) begin
      logic [11:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wr_frame_content: got %h, required %h", o, e);
      end
    end
  endtask

  task automatic test_full_read;
    logic [7:0] a, d, exp_d;
    int k, base;
    for (int it = 0; it < 4; it++) begin
      a = (it == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      d = (it == 0) ? 8'h5C : 8'($urandom_range(0, 255));
      base = rsp_cnt[0];
      issue(0, 2'b00, a, k); wait_idle(0);
      issue(0, 2'b01, d, k); wait_idle(0);
      issue(0, 2'b10, a, k); wait_idle(0);
      issue(0, 2'b11, 8'($urandom_range(0, 255)), k);
      exp_d = ref_ram[0][ref_addr[0]];
      for (int m = 1; m <= 21 + RW0; m++) begin
        wait_edge(k + m);
        checks++;
        if (rsp_valid_v[0] !== (m == 20 + RW0)) begin
          errors++;
          $display("FAIL rd_valid_timing it=%0d m=%0d: rsp_valid=%b, required %b", it, m, rsp_valid_v[0], (m == 20 + RW0));
        end
        if (m == 20 + RW0) begin
          checks++;
          if (rsp_data_a[0] !== exp_d || ss_n_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL rd_data it=%0d: rsp_data=%h ss_n=%b, required %h 1", it, rsp_data_a[0], ss_n_v[0], exp_d);
          end
        end
      end
      wait_idle(0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rsp_cnt[0] - base != 1 || rsp_data_a[0] !== exp_d) begin
        errors++;
        $display("FAIL rd_pulse_count it=%0d: pulses=%0d data=%h, required 1 %h", it, rsp_cnt[0] - base, rsp_data_a[0], exp_d);
      end
    end
    while (exp_q.size() > 0) begin
      logic [11:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rd_frame_content: got %h, required %h", o, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ops[4];
    logic [7:0] dats[4];
    int ks[4];
    int n, lc0;
    for (int i = 0; i < 4; i++) begin
      ops[i]  = 2'($urandom_range(0, 2));
      dats[i] = 8'($urandom_range(0, 255));
    end
    lc0 = low_cnt[0];
    @(negedge clk);
    cmd_valid_v[0] = 1'b1;
    cmd_op_a[0]    = ops[0];
    cmd_data_a[0]  = dats[0];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (ready_v[0] !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 100) begin
        errors++;
        $display("FAIL b2b_accept_timeout #%0d: cmd_ready=%b, required 1", i, ready_v[0]);
      end
      @(posedge clk); #1;
      ks[i] = cyc;
      model_cmd(0, ops[i], dats[i]);
      if (i < 3) begin
        cmd_op_a[0]   = ops[i + 1];
        cmd_data_a[0] = dats[i + 1];
      end else begin
        cmd_valid_v[0] = 1'b0;
      end
    end
    wait_idle(0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ks[i + 1] - ks[i] != 12 + G0) begin
        errors++;
        $display("FAIL b2b_interval #%0d: %0d edges, required %0d", i, ks[i + 1] - ks[i], 12 + G0);
      end
    end
    checks++;
    if (low_cnt[0] - lc0 != 44) begin
      errors++;
      $display("FAIL b2b_ss_low_total: %0d cycles, required 44", low_cnt[0] - lc0);
    end
    while (exp_q.size() > 0) begin
      logic [11:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_frame_content: got %h, required %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int k, base, lc0;
    issue(0, 2'b11, 8'($urandom_range(0, 255)), k);
    wait_edge(k + 14);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ss_n_v[0] !== 1'b1 || mosi_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || rsp_data_a[0] !== 8'h00) begin
      errors++;
      $display("FAIL abort_outputs: ss_n=%b mosi=%b busy=%b rsp_data=%h, required 1 0 0 00",
               ss_n_v[0], mosi_v[0], busy_v[0], rsp_data_a[0]);
    end
    rst = 1'b0;
    base = rsp_cnt[0];
    wait_edge(k + 32);
    checks++;
    if (rsp_cnt[0] != base || rsp_data_a[0] !== 8'h00 || ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_rsp: pulses=%0d rsp_data=%h cmd_ready=%b, required 0 00 1",
               rsp_cnt[0] - base, rsp_data_a[0], ready_v[0]);
    end
    lc0 = low_cnt[0];
    issue(0, 2'b00, 8'($urandom_range(0, 255)), k);
    wait_idle(0);
    checks++;
    if (low_cnt[0] - lc0 != 11) begin
      errors++;
      $display("FAIL abort_next_write_len: %0d cycles, required 11", low_cnt[0] - lc0);
    end
    while (exp_q.size() > 0) begin
      logic [11:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_frame_content: got %h, required %h", o, e);
      end
    end
  endtask

  task automatic test_rd_wait0;
    logic [7:0] a;
    int k1, k2, k;
    a = 8'($urandom_range(0, 255));
    issue(1, 2'b00, a, k1);
    issue(1, 2'b01, 8'hA5, k2);
    checks++;
    if (k2 - k1 != 12 + G1) begin
      errors++;
      $display("FAIL w0_write_gap: %0d edges, required %0d", k2 - k1, 12 + G1);
    end
    issue(1, 2'b10, a, k1);
    issue(1, 2'b11, 8'h00, k);
    for (int m = 1; m <= 21 + RW1; m++) begin
      wait_edge(k + m);
      checks++;
      if (rsp_valid_v[1] !== (m == 20 + RW1)) begin
        errors++;
        $display("FAIL w0_valid_timing m=%0d: rsp_valid=%b, required %b", m, rsp_valid_v[1], (m == 20 + RW1));
      end
      if (m == 20 + RW1) begin
        checks++;
        if (rsp_data_a[1] !== 8'hA5) begin
          errors++;
          $display("FAIL w0_data: rsp_data=%h, required a5", rsp_data_a[1]);
        end
      end
    end
    issue(1, 2'b00, 8'($urandom_range(0, 255)), k2);
    checks++;
    if (k2 - k != 20 + RW1 + G1) begin
      errors++;
      $display("FAIL w0_read_gap: %0d edges, required %0d", k2 - k, 20 + RW1 + G1);
    end
    wait_idle(1);
    while (exp_q.size() > 0) begin
      logic [11:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL w0_frame_content: got %h, required %h", o, e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cmd_op_a[0] = 2'b00; cmd_op_a[1] = 2'b00;
    cmd_data_a[0] = 8'h00; cmd_data_a[1] = 8'h00;
    test_reset();
    test_write_frames();
    test_full_read();
    test_back_to_back();
    test_reset_mid_read();
    test_rd_wait0();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL stray_frames: %0d unexpected frames, required 0", obs_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
